// File: rtl/synth_pkg.sv
// Shared widths, glide step and state encoding for the synth voice blocks.
// Optional portamento is enabled by defining GLIDE_EN.
package synth_pkg;

  localparam int ACC_W_DEF      = 24;
  localparam int PHASE_W_DEF    = 8;
  localparam int TUNE_W_DEF     = 16;
  localparam int GLIDE_STEP_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef GLIDE_EN
    ,
    SLEW = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/tune_slew.sv
// Portamento stepper: moves the increment one step toward the target,
// clamping on the target so it never overshoots.
module tune_slew
  import synth_pkg::*;
#(
  parameter int TUNE_W     = TUNE_W_DEF,
  parameter int GLIDE_STEP = GLIDE_STEP_DEF
) (
  input  logic [TUNE_W-1:0] i_inc,
  input  logic [TUNE_W-1:0] i_target,
  output logic [TUNE_W-1:0] o_next
);

  localparam logic [TUNE_W-1:0] W_STEP = TUNE_W'(GLIDE_STEP);

  logic [TUNE_W-1:0] w_up;
  logic [TUNE_W-1:0] w_dn;

  assign w_up = i_target - i_inc;
  assign w_dn = i_inc - i_target;

  always_comb begin
    o_next = i_target;
    if (i_target > i_inc) begin
      if (w_up > W_STEP) o_next = i_inc + W_STEP;
    end else if (i_inc > i_target) begin
      if (w_dn > W_STEP) o_next = i_inc - W_STEP;
    end
  end

endmodule

// File: rtl/phase_accumulator.sv
// NCO phase accumulator with gate/sync control and tuning handshake.
// Define GLIDE_EN to add portamento (SLEW state + tune_slew stepper).
module phase_accumulator
  import synth_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int TUNE_W  = TUNE_W_DEF
`ifdef GLIDE_EN
  ,
  parameter int GLIDE_STEP = GLIDE_STEP_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               gate,
  input  logic               hard_sync,
  input  logic               tune_valid,
  input  logic [TUNE_W-1:0]  tune_word,
  output logic               tune_ready,
  output logic [PHASE_W-1:0] period,
  output logic               wrap,
  output logic               active
);

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [TUNE_W-1:0]  r_inc;
  logic               r_wrap;
  logic               r_active;
  logic               r_rdy;
  logic               r_gate_d;

  logic [ACC_W:0]     w_sum;
  logic               w_add;
  logic               w_rise;
  logic               w_accept;

  assign w_sum    = {1'b0, r_acc}
                  + {{(ACC_W + 1 - TUNE_W){1'b0}}, r_inc};
  assign w_add    = (r_state != IDLE) && sample_tick;
  assign w_rise   = gate && !r_gate_d;
  assign w_accept = tune_valid && tune_ready;

`ifdef GLIDE_EN
  logic [TUNE_W-1:0] r_target;
  logic [TUNE_W-1:0] w_inc_next;

  tune_slew #(
    .TUNE_W     (TUNE_W),
    .GLIDE_STEP (GLIDE_STEP)
  ) u_slew (
    .i_inc    (r_inc),
    .i_target (r_target),
    .o_next   (w_inc_next)
  );

  assign tune_ready = r_rdy && (r_state != SLEW);
`else
  // Without glide the target and the live increment are one register.
  assign tune_ready = r_rdy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_inc    <= '0;
      r_wrap   <= 1'b0;
      r_active <= 1'b0;
      r_rdy    <= 1'b0;
      r_gate_d <= 1'b0;
`ifdef GLIDE_EN
      r_target <= '0;
`endif
    end else begin
      r_rdy    <= 1'b1;
      r_gate_d <= gate;
      r_wrap   <= 1'b0;
      if (w_add) {r_wrap, r_acc} <= w_sum;
      if (!gate) begin
        r_state  <= IDLE;
        r_active <= 1'b0;
      end else if (w_rise && r_state == IDLE) begin
        r_state  <= RUN;
        r_active <= 1'b1;
        r_acc    <= '0;
      end
`ifdef GLIDE_EN
      else if (r_state == RUN && w_accept
               && tune_word != r_inc)
        r_state <= SLEW;
      else if (r_state == SLEW && sample_tick
               && w_inc_next == r_target)
        r_state <= RUN;
      if (w_accept) r_target <= tune_word;
      // While the note is off there is nothing to glide from: snap.
      if (r_state == IDLE)
        r_inc <= w_accept ? tune_word : r_target;
      else if (r_state == SLEW && sample_tick)
        r_inc <= w_inc_next;
`else
      if (w_accept) r_inc <= tune_word;
`endif
      if (hard_sync) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
      end
    end
  end

  assign period = r_acc[ACC_W-1 -: PHASE_W];
  assign wrap   = r_wrap;
  assign active = r_active;

endmodule

// File: doc/phase_accumulator.md
PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits.
REQ-002 Parameter PHASE_W, default 8: output phase width; drives the sine generator's `period` input.
REQ-003 Parameter TUNE_W, default 16: tuning word width; TUNE_W SHALL be at most ACC_W.
REQ-004 clk  input  1: single clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1: reset; asynchronous, active-high.
REQ-006 sample_tick  input  1: one-cycle strobe that advances the phase by one sample.
REQ-007 gate  input  1: note on while high.
REQ-008 hard_sync  input  1: oscillator sync; clears the phase.
REQ-009 tune_valid  input  1: a tuning word is offered.
REQ-010 tune_word  input  TUNE_W: phase increment per sample.
REQ-011 tune_ready  output  1: the block can accept a tuning word.
REQ-012 period  output  PHASE_W: phase, taken as acc[ACC_W-1 -: PHASE_W].
REQ-013 wrap  output  1: one-cycle pulse on accumulator overflow.
REQ-014 active  output  1: high while the state machine is not in IDLE.

Function
REQ-015 State machine SHALL have states IDLE and RUN, plus SLEW when GLIDE_EN is defined.
REQ-016 Transitions:
- IDLE->RUN on a gate rising edge, with acc cleared to 0 in the same cycle.
- Any state->IDLE when gate is low.
- In IDLE, acc and period SHALL hold.
REQ-017 In RUN/SLEW with sample_tick=1: acc <= (acc + zero-extended inc) mod 2^ACC_W.
REQ-018 wrap SHALL be 1 for exactly the cycle after an add that produced a carry out of bit ACC_W-1, and 0 otherwise.
REQ-019 hard_sync=1: acc <= 0 that cycle.
- Priority: hard_sync over tick and over the gate edge.
- A synced cycle SHALL NOT raise wrap.
REQ-020 A tuning word is accepted when tune_valid && tune_ready at a rising clk edge.
- tune_word SHALL be captured into the target register.
- Without GLIDE_EN, tune_word SHALL also be captured into inc in that cycle.
REQ-021 A sample_tick coincident with acceptance SHALL add the old inc; the new inc applies from the next tick.
REQ-022 Without GLIDE_EN, tune_ready SHALL be 1 in every cycle except reset and the first cycle after reset release.
REQ-023 period SHALL be a direct slice of the acc register, with no extra latency.
REQ-024 With tune_word=0 in RUN, period SHALL hold and wrap SHALL stay 0.

Reset
REQ-025 rst high SHALL immediately force acc=0, inc=0, target=0, state=IDLE, period=0, wrap=0, active=0, tune_ready=0.
REQ-026 tune_ready SHALL rise one clk after rst deasserts.
REQ-027 rst asserted mid-RUN or mid-SLEW SHALL abort the operation with no residual wrap pulse.

Configuration
REQ-028 Macro GLIDE_EN SHALL control portamento.
REQ-029 With GLIDE_EN defined:
- Acceptance sets target and enters SLEW when inc != target.
- Each sample_tick moves inc toward target by parameter GLIDE_STEP (default 16), clamped with no overshoot.
- SLEW->RUN when inc == target.
- tune_ready SHALL be 0 while in SLEW.
- The add on a tick SHALL use the pre-step inc.
REQ-030 Without GLIDE_EN, no SLEW state and no GLIDE_STEP logic SHALL exist; behaviour SHALL follow REQ-020 to REQ-022.

Structure
REQ-031 ACC_W, PHASE_W and TUNE_W defaults, GLIDE_STEP, and the state enum (IDLE/RUN/SLEW) SHALL live in the shared package synth_pkg.
REQ-032 The glide stepper SHALL be sub-module tune_slew, instantiated only under GLIDE_EN; the rest SHALL be flat.

Verification
REQ-033 The bench SHALL cover at least the following directed scenarios (defaults; without GLIDE_EN unless stated):
- tune 0x1000, gate rise, 4096 ticks -> period increments by 1 every 16 ticks; exactly one wrap pulse, after tick 4096; period returns to 0x00.
- rst asserted asynchronously mid-RUN at period=0x5A -> period=0, wrap=0, active=0 before the next clk edge; tune_ready=1 one cycle after release.
- acc=0x7F0000, hard_sync with sample_tick in the same cycle -> acc=0, period=0x00, no wrap.
- inc=0x1000, accept 0x2000 in the same cycle as a tick -> that tick adds 0x1000; the next tick adds 0x2000.
- gate low at period=0x40, 10 ticks -> period stays 0x40, active=0; gate rise -> period=0x00.
- GLIDE_EN, inc=0x0100, accept 0x0135 -> inc 0x0110, 0x0120, 0x0130, 0x0135 on successive ticks; tune_ready=0 during SLEW, back to 1 in RUN.
